// File: rtl/phased_tag_ctrl_pkg.sv
// Shared constants and state encoding for the phased cache tag controller.
package phased_tag_ctrl_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned WAYS_DEF  = 4;
    localparam int unsigned TAG_W_DEF = 26;
    localparam int unsigned SET_W_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TAG  = 3'd1,
        S_DATA = 3'd2,
        S_MREQ = 3'd3,
        S_FILL = 3'd4,
        S_RESP = 3'd5
    } state_t;

endpackage

// File: rtl/phased_tag_ctrl_rr_ptr_bank.sv
// Per-set round-robin replacement pointers with one read and one write port.
module rr_ptr_bank #(
    parameter int unsigned SET_W = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SET_W-1:0] rd_set,
    output logic [PTR_W-1:0] rd_ptr_c,
    input  logic             wr_en,
    input  logic [SET_W-1:0] wr_set,
    input  logic [PTR_W-1:0] wr_ptr
);

    localparam int unsigned SETS = 1 << SET_W;

    logic [PTR_W-1:0] ptr_q [SETS];

    // Pointer storage: cleared on reset, updated on a fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(SETS); i++) begin
                ptr_q[i] <= '0;
            end
        end else if (wr_en) begin
            ptr_q[wr_set] <= wr_ptr;
        end
    end

    assign rd_ptr_c = ptr_q[rd_set];

endmodule

// File: rtl/phased_tag_ctrl.sv
// Phased cache controller: tag compare first, data read only from the hitting way.
module phased_tag_ctrl
    import phased_tag_ctrl_pkg::*;
#(
    parameter int unsigned WAYS  = WAYS_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF,
    parameter int unsigned SET_W = SET_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic [SET_W-1:0]         set_idx,
    input  logic [WAYS*TAG_W-1:0]    tags_in,
    input  logic [WAYS-1:0]          valid_in,
    output logic                     data_rd_en,
    output logic [$clog2(WAYS)-1:0]  data_way,
    input  logic [ADDR_W-1:0]        data_in,
    output logic [WAYS-1:0]          tag_we,
    output logic [TAG_W-1:0]         tag_wdata,
    output logic                     data_we,
    output logic [ADDR_W-1:0]        data_wdata,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_ack,
    input  logic [ADDR_W-1:0]        mem_rdata,
    output logic                     resp_valid,
    output logic [ADDR_W-1:0]        resp_data,
    output logic                     resp_hit
);

    localparam int unsigned WAY_W = $clog2(WAYS);

    state_t             state;
    logic [TAG_W-1:0]   tag_q;
    logic [WAY_W-1:0]   victim_q;

    logic               hit_c;
    logic [WAY_W-1:0]   hit_way_c;
    logic               inv_found_c;
    logic [WAY_W-1:0]   inv_way_c;
    logic [WAY_W-1:0]   victim_c;
    logic [WAY_W-1:0]   rr_ptr_c;
    logic               rr_we_c;
    logic [WAY_W-1:0]   rr_next_c;

    // Byte offset of a word-aligned address carries no information.
    logic               unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, req_addr[1:0]};

    // Tag comparator and victim priority encoder; lowest index wins in both.
    always_comb begin
        hit_c       = 1'b0;
        hit_way_c   = '0;
        inv_found_c = 1'b0;
        inv_way_c   = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_in[w] && (tags_in[w*TAG_W +: TAG_W] == tag_q)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (!valid_in[w]) begin
                inv_found_c = 1'b1;
                inv_way_c   = WAY_W'(w);
            end
        end
        victim_c = inv_found_c ? inv_way_c : rr_ptr_c;
    end

    // Round-robin pointer advances past the victim on every fill.
    assign rr_we_c   = (state == S_FILL);
    assign rr_next_c = victim_q + WAY_W'(1);

    rr_ptr_bank #(
        .SET_W (SET_W),
        .PTR_W (WAY_W)
    ) u_rr_ptr_bank (
        .clk      (clk),
        .reset    (reset),
        .rd_set   (set_idx),
        .rd_ptr_c (rr_ptr_c),
        .wr_en    (rr_we_c),
        .wr_set   (set_idx),
        .wr_ptr   (rr_next_c)
    );

    // Sequencer with registered outputs; each output is set on entry to the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            set_idx    <= '0;
            tag_q      <= '0;
            victim_q   <= '0;
            data_rd_en <= 1'b0;
            data_way   <= '0;
            tag_we     <= '0;
            tag_wdata  <= '0;
            data_we    <= 1'b0;
            data_wdata <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_hit   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        tag_q     <= req_addr[ADDR_W-1 -: TAG_W];
                        set_idx   <= req_addr[SET_W+1:2];
                        req_ready <= 1'b0;
                        state     <= S_TAG;
                    end
                end
                S_TAG: begin
                    victim_q <= victim_c;
                    if (hit_c) begin
                        data_rd_en <= 1'b1;
                        data_way   <= hit_way_c;
                        state      <= S_DATA;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= {tag_q, set_idx, 2'b00};
                        state    <= S_MREQ;
                    end
                end
                S_DATA: begin
                    data_rd_en <= 1'b0;
                    resp_data  <= data_in;
                    resp_hit   <= 1'b1;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_MREQ: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        data_wdata <= mem_rdata;
                        resp_data  <= mem_rdata;
                        resp_hit   <= 1'b0;
                        tag_we     <= WAYS'(1) << victim_q;
                        tag_wdata  <= tag_q;
                        data_we    <= 1'b1;
                        data_way   <= victim_q;
                        state      <= S_FILL;
                    end
                end
                S_FILL: begin
                    tag_we     <= '0;
                    data_we    <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phased_tag_ctrl.sv
// Directed bench for phased_tag_ctrl: hits, misses, replacement and reset.
module tb_phased_tag_ctrl;

    localparam int unsigned WAYS  = 4;
    localparam int unsigned TAG_W = 26;
    localparam int unsigned SET_W = 4;

    logic                  clk;
    logic                  reset;
    logic                  req_valid;
    logic                  req_ready;
    logic [31:0]           req_addr;
    logic [SET_W-1:0]      set_idx;
    logic [WAYS*TAG_W-1:0] tags_in;
    logic [WAYS-1:0]       valid_in;
    logic                  data_rd_en;
    logic [1:0]            data_way;
    logic [31:0]           data_in;
    logic [WAYS-1:0]       tag_we;
    logic [TAG_W-1:0]      tag_wdata;
    logic                  data_we;
    logic [31:0]           data_wdata;
    logic                  mem_req;
    logic [31:0]           mem_addr;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;
    logic                  resp_valid;
    logic [31:0]           resp_data;
    logic                  resp_hit;

    int passed;
    int total;
    int rd_en_cnt;

    phased_tag_ctrl #(
        .WAYS  (WAYS),
        .TAG_W (TAG_W),
        .SET_W (SET_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .set_idx    (set_idx),
        .tags_in    (tags_in),
        .valid_in   (valid_in),
        .data_rd_en (data_rd_en),
        .data_way   (data_way),
        .data_in    (data_in),
        .tag_we     (tag_we),
        .tag_wdata  (tag_wdata),
        .data_we    (data_we),
        .data_wdata (data_wdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_hit   (resp_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every cycle in which the data array read strobe is high.
    always @(negedge clk) begin
        if (data_rd_en === 1'b1) rd_en_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        total++; if (req_ready !== 1'b1) $display("FAIL reset req_ready: got %b exp 1", req_ready); else passed++;
        total++; if ({mem_req, resp_valid, data_rd_en, data_we, tag_we} !== 8'h00)
            $display("FAIL reset strobes: got %b exp 00000000", {mem_req, resp_valid, data_rd_en, data_we, tag_we}); else passed++;
        total++; if ({set_idx, mem_addr, resp_data} !== 68'h0)
            $display("FAIL reset regs: got %h exp 0", {set_idx, mem_addr, resp_data}); else passed++;
    endtask

    // Miss flow: mem_ack arrives ack_delay cycles after the first MREQ cycle.
    task automatic run_miss(input string name, input logic [31:0] addr, input logic [3:0] vld,
                            input int ack_delay, input logic [31:0] rdata, input logic [1:0] exp_victim);
        int rd0;
        logic [25:0] exp_tag;
        logic [3:0]  exp_we;
        exp_tag = addr[31:6];
        exp_we  = 4'b0001 << exp_victim;
        rd0 = rd_en_cnt;
        tags_in  = {4{26'h3FF_FFFF}};
        valid_in = vld;
        req_addr = addr;
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        total++; if ({req_ready, set_idx} !== {1'b0, addr[5:2]})
            $display("FAIL %s tag_phase: got ready/set %b/%h exp 0/%h", name, req_ready, set_idx, addr[5:2]); else passed++;
        cyc();
        total++; if ({mem_req, mem_addr} !== {1'b1, addr})
            $display("FAIL %s mem_req: got %b %h exp 1 %h", name, mem_req, mem_addr, addr); else passed++;
        for (int i = 0; i < ack_delay; i++) cyc();
        mem_ack = 1'b1;
        mem_rdata = rdata;
        cyc();
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        total++; if (tag_we !== exp_we) $display("FAIL %s tag_we: got %b exp %b", name, tag_we, exp_we); else passed++;
        total++; if ({tag_wdata, data_we, data_way, data_wdata, mem_req, resp_valid} !== {exp_tag, 1'b1, exp_victim, rdata, 2'b00})
            $display("FAIL %s fill: got %h %b %0d %h %b%b exp %h 1 %0d %h 00", name,
                     tag_wdata, data_we, data_way, data_wdata, mem_req, resp_valid, exp_tag, exp_victim, rdata); else passed++;
        cyc();
        total++; if ({resp_valid, resp_hit, resp_data, tag_we, data_we} !== {2'b10, rdata, 5'b0})
            $display("FAIL %s resp: got v%b h%b %h we %b/%b exp v1 h0 %h", name,
                     resp_valid, resp_hit, resp_data, tag_we, data_we, rdata); else passed++;
        cyc();
        total++; if ({resp_valid, req_ready} !== 2'b01)
            $display("FAIL %s idle: got v%b r%b exp v0 r1", name, resp_valid, req_ready); else passed++;
        total++; if (rd_en_cnt !== rd0) $display("FAIL %s rd_en_on_miss: got %0d exp %0d", name, rd_en_cnt, rd0); else passed++;
    endtask

    // Hit flow: accept edge T, TAG at T+1, DATA at T+2, RESP at T+3.
    task automatic run_hit(input string name, input logic [31:0] addr, input logic [103:0] tags,
                           input logic [3:0] vld, input logic [31:0] din, input logic [1:0] exp_way);
        tags_in  = tags;
        valid_in = vld;
        data_in  = din;
        req_addr = addr;
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        total++; if ({req_ready, data_rd_en, mem_req, resp_valid} !== 4'b0000)
            $display("FAIL %s t1: got %b exp 0000", name, {req_ready, data_rd_en, mem_req, resp_valid}); else passed++;
        cyc();
        total++; if ({data_rd_en, data_way, mem_req, resp_valid} !== {1'b1, exp_way, 2'b00})
            $display("FAIL %s t2: got rd%b way%0d mreq%b v%b exp rd1 way%0d mreq0 v0", name,
                     data_rd_en, data_way, mem_req, resp_valid, exp_way); else passed++;
        cyc();
        total++; if ({resp_valid, resp_hit, resp_data, data_rd_en, mem_req} !== {2'b11, din, 2'b00})
            $display("FAIL %s t3: got v%b h%b %h rd%b mreq%b exp v1 h1 %h rd0 mreq0", name,
                     resp_valid, resp_hit, resp_data, data_rd_en, mem_req, din); else passed++;
        cyc();
        total++; if ({resp_valid, req_ready} !== 2'b01)
            $display("FAIL %s idle: got v%b r%b exp v0 r1", name, resp_valid, req_ready); else passed++;
    endtask

    task automatic test_cold_miss();
        run_miss("cold_miss", 32'h0000_0040, 4'b0000, 2, 32'hDEAD_BEEF, 2'd0);
    endtask

    task automatic test_hit();
        run_hit("hit", 32'h0000_554C, {26'h156, 26'h155, 26'h154, 26'h100}, 4'b1111, 32'h1234_5678, 2'd2);
        run_hit("multi_hit", 32'h0000_554C, {26'h155, 26'h123, 26'h155, 26'h155}, 4'b1110, 32'hCAFE_F00D, 2'd1);
    endtask

    task automatic test_round_robin();
        logic [31:0] a;
        logic [1:0]  exp_v [6];
        exp_v = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 6; i++) begin
            a = {26'(32'h10 + i), 4'd5, 2'b00};
            run_miss($sformatf("rr%0d", i), a, 4'b1111, 1, 32'hA000_0000 + 32'(i), exp_v[i]);
        end
    endtask

    task automatic test_invalid_pref();
        run_miss("inv_pref", {26'h77, 4'd7, 2'b00}, 4'b1011, 0, 32'h0BAD_CAFE, 2'd2);
        run_miss("inv_pref_rr", {26'h78, 4'd7, 2'b00}, 4'b1111, 0, 32'h0BAD_CAFF, 2'd3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        a = {26'h50, 4'd9, 2'b00};
        b = {26'h2A, 4'd9, 2'b00};
        tags_in  = {4{26'h3FF_FFFF}};
        valid_in = 4'b0000;
        req_addr = a;
        req_valid = 1'b1;
        cyc();
        req_addr = b;
        total++; if (req_ready !== 1'b0) $display("FAIL b2b tag ready: got %b exp 0", req_ready); else passed++;
        cyc();
        total++; if ({mem_req, req_ready} !== 2'b10) $display("FAIL b2b mreq: got %b exp 10", {mem_req, req_ready}); else passed++;
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        cyc();
        mem_ack = 1'b0;
        total++; if ({tag_we, data_we, req_ready} !== 6'b000110)
            $display("FAIL b2b fill: got %b exp 000110", {tag_we, data_we, req_ready}); else passed++;
        cyc();
        total++; if ({resp_valid, resp_hit, resp_data, req_ready} !== {2'b10, 32'h5555_AAAA, 1'b0})
            $display("FAIL b2b resp: got v%b h%b %h r%b exp v1 h0 5555aaaa r0", resp_valid, resp_hit, resp_data, req_ready); else passed++;
        cyc();
        total++; if ({req_ready, resp_valid} !== 2'b10) $display("FAIL b2b idle: got %b exp 10", {req_ready, resp_valid}); else passed++;
        tags_in  = {26'h2A, 26'h3FF_FFFF, 26'h3FF_FFFF, 26'h3FF_FFFF};
        valid_in = 4'b1000;
        data_in  = 32'h0F0F_0F0F;
        cyc();
        req_valid = 1'b0;
        total++; if ({req_ready, set_idx} !== {1'b0, 4'd9})
            $display("FAIL b2b second accept: got r%b set%h exp r0 set9", req_ready, set_idx); else passed++;
        cyc();
        total++; if ({data_rd_en, data_way} !== 3'b111) $display("FAIL b2b second data: got %b exp 111", {data_rd_en, data_way}); else passed++;
        cyc();
        total++; if ({resp_valid, resp_hit, resp_data} !== {2'b11, 32'h0F0F_0F0F})
            $display("FAIL b2b second resp: got v%b h%b %h exp v1 h1 0f0f0f0f", resp_valid, resp_hit, resp_data); else passed++;
        cyc();
    endtask

    task automatic test_reset_mid_miss();
        tags_in  = {4{26'h3FF_FFFF}};
        valid_in = 4'b0000;
        req_addr = {26'h99, 4'd11, 2'b00};
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        cyc();
        total++; if (mem_req !== 1'b1) $display("FAIL rst_mid pre mem_req: got %b exp 1", mem_req); else passed++;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        total++; if ({mem_req, tag_we, data_we, resp_valid, req_ready} !== 8'b00000001)
            $display("FAIL rst_mid after: got %b exp 00000001", {mem_req, tag_we, data_we, resp_valid, req_ready}); else passed++;
        mem_ack = 1'b1;
        mem_rdata = 32'h1111_2222;
        cyc();
        mem_ack = 1'b0;
        total++; if ({mem_req, tag_we, data_we, resp_valid, req_ready} !== 8'b00000001)
            $display("FAIL rst_mid stray ack: got %b exp 00000001", {mem_req, tag_we, data_we, resp_valid, req_ready}); else passed++;
        cyc();
        total++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL rst_mid late: got %b exp 01", {resp_valid, req_ready}); else passed++;
        // Pointer for set 5 was 2 before reset; after reset it must start again at way 0.
        run_miss("rr_after_reset", {26'h40, 4'd5, 2'b00}, 4'b1111, 0, 32'h7777_8888, 2'd0);
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rd_en_cnt = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        tags_in   = '0;
        valid_in  = '0;
        data_in   = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;

        test_reset();
        test_cold_miss();
        test_hit();
        test_round_robin();
        test_invalid_pref();
        test_back_to_back();
        test_reset_mid_miss();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
